ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 21 ++
 rtl/ccff_bitstream_loader_serializer.sv | 40 ++++
 rtl/ccff_bitstream_loader.sv | 130 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
// Imported by the loader top and its byte serializer.
package ccff_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    FINISH
  } state_e;

  // Bits shifted from the final byte of a chain of the given length
  function automatic logic [3:0] bits_in_last_byte(input int chain_len);
    int r;
    r = chain_len % BYTE_W;
    return (r == 0) ? 4'(BYTE_W) : 4'(r);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_serializer.sv
// Byte buffer for the loader: holds one byte and the count of its bits
// still to be shifted out MSB-first.
module ccff_byte_serializer
  import ccff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
  input  logic [3:0]        load_bits,
  output logic              msb,
  output logic              next_msb,
  output logic [3:0]        bits_left,
  output logic              empty,
  output logic              last
);

  logic [BYTE_W-1:0] buf_q;

  // A load in the same cycle as the final shift replaces the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      bits_left <= '0;
    end else if (load) begin
      buf_q     <= data;
      bits_left <= load_bits;
    end else if (shift && !empty) begin
      buf_q     <= buf_q << 1;
      bits_left <= bits_left - 4'd1;
    end
  end

  assign msb      = buf_q[BYTE_W-1];
  assign next_msb = buf_q[BYTE_W-2];
  assign empty    = (bits_left == 4'd0);
  assign last     = (bits_left == 4'd1);

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds a tile configuration chain from a byte stream, MSB first,
// with an optional verify pass that checks ccff_tail against the data.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] BYTE_LEN  = CNT_W'(BYTE_W);
  localparam logic [3:0]       LAST_BITS = bits_in_last_byte(CHAIN_LEN);

  state_e           state;
  logic             verify_r;
  logic             hs;
  logic             ser_shift;
  logic             ser_msb;
  logic             ser_next;
  logic             ser_empty;
  logic             ser_last;
  logic [3:0]       ser_left;
  logic [3:0]       load_bits;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] rem;

  assign hs        = din_valid && din_ready;
  assign ser_shift = (state == SHIFT) && !ser_empty;
  assign cnt_next  = ser_shift ? bit_cnt + ONE : bit_cnt;
  assign rem       = LEN - cnt_next;
  // Only the final byte of the chain can be partial
  assign load_bits = (rem > BYTE_LEN) ? 4'(BYTE_W) : LAST_BITS;

  ccff_byte_serializer u_ser (
    .clk       (prog_clk),
    .rst       (pReset),
    .load      (hs),
    .shift     (ser_shift),
    .data      (din),
    .load_bits (load_bits),
    .msb       (ser_msb),
    .next_msb  (ser_next),
    .bits_left (ser_left),
    .empty     (ser_empty),
    .last      (ser_last)
  );

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state       <= IDLE;
      verify_r    <= 1'b0;
      din_ready   <= 1'b0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            verify_r  <= verify;
            bit_cnt   <= '0;
            error     <= 1'b0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (hs) begin
            state       <= SHIFT;
            din_ready   <= 1'b0;
            ccff_head   <= din[BYTE_W-1];
            ccff_clk_en <= 1'b1;
          end
        end
        SHIFT: begin
          bit_cnt <= cnt_next;
          if (verify_r && (ccff_tail != ser_msb)) error <= 1'b1;
          if (cnt_next == LEN) begin
            state       <= FINISH;
            done        <= 1'b1;
            din_ready   <= 1'b0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
          end else if (ser_last) begin
            // Next byte ready on the last bit keeps the shift stream gapless
            if (hs) begin
              din_ready <= 1'b0;
              ccff_head <= din[BYTE_W-1];
            end else begin
              state       <= FETCH;
              din_ready   <= 1'b1;
              ccff_head   <= 1'b0;
              ccff_clk_en <= 1'b0;
            end
          end else begin
            ccff_head <= ser_next;
            din_ready <= (ser_left == 4'd2) && (cnt_next + ONE < LEN);
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: 8-bit and 10-bit chains with
// behavioural chain models and a head-bit scoreboard.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_verify, a_din_valid, a_din_ready;
  logic        a_head, a_en, a_tail, a_busy, a_done, a_error;
  logic [7:0]  a_din;
  logic [15:0] a_cnt;
  logic        b_rst, b_start, b_verify, b_din_valid, b_din_ready;
  logic        b_head, b_en, b_tail, b_busy, b_done, b_error;
  logic [7:0]  b_din;
  logic [15:0] b_cnt;

  ccff_bitstream_loader #(.CHAIN_LEN(8), .CNT_W(16)) u_a (
    .prog_clk(clk), .pReset(a_rst), .start(a_start), .verify(a_verify),
    .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .ccff_head(a_head), .ccff_clk_en(a_en), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .error(a_error), .bit_cnt(a_cnt)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(10), .CNT_W(16)) u_b (
    .prog_clk(clk), .pReset(b_rst), .start(b_start), .verify(b_verify),
    .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .ccff_head(b_head), .ccff_clk_en(b_en), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .error(b_error), .bit_cnt(b_cnt)
  );

  // Chain models: first bit shifted in ends at the MSB and leaves first
  logic [7:0] chain_a = '0;
  logic [7:0] stuck_a = '0;
  logic [9:0] chain_b = '0;
  always @(posedge clk) if (a_en) chain_a <= {chain_a[6:0], a_head} & ~stuck_a;
  always @(posedge clk) if (b_en) chain_b <= {chain_b[8:0], b_head};
  assign a_tail = chain_a[7];
  assign b_tail = chain_b[9];

  bit q_a[$];
  bit q_b[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int en_n_a = 0, first_a = -1, last_a = -1, rdy_a = 0, en_tot_a = 0;
  int en_n_b = 0, first_b = -1, last_b = -1, rdy_b = 0;
  logic bprev_a = 1'b0, bprev_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (a_busy && !bprev_a) begin
        en_n_a = 0; first_a = -1; last_a = -1; rdy_a = 0;
      end
      bprev_a = a_busy;
      if (a_en) begin
        en_n_a++;
        en_tot_a++;
        if (first_a < 0) first_a = cyc;
        last_a = cyc;
        if (a_din_ready) rdy_a = en_n_a;
        if (q_a.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL a_extra_shift: head=%0b, required no shift", a_head);
        end else check("a_head", 32'(a_head), 32'(q_a.pop_front()));
      end
      if (b_busy && !bprev_b) begin
        en_n_b = 0; first_b = -1; last_b = -1; rdy_b = 0;
      end
      bprev_b = b_busy;
      if (b_en) begin
        en_n_b++;
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        if (b_din_ready) rdy_b = en_n_b;
        if (q_b.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL b_extra_shift: head=%0b, required no shift", b_head);
        end else check("b_head", 32'(b_head), 32'(q_b.pop_front()));
      end
    end
  endtask

  task automatic push_a(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) q_a.push_back(bits[i]);
  endtask

  task automatic push_b(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) q_b.push_back(bits[i]);
  endtask

  task automatic go_a(input logic v);
    @(posedge clk); #1 a_start = 1'b1; a_verify = v;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic go_b(input logic v);
    @(posedge clk); #1 b_start = 1'b1; b_verify = v;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    int t;
    logic hs;
    a_din = d; a_din_valid = 1'b1; t = 0; hs = 1'b0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = a_din_ready;
      @(posedge clk); t++;
    end
    #1 a_din_valid = 1'b0;
    if (!hs) begin
      compared++; mismatched++;
      $display("FAIL a_send_timeout: din_ready=0 for %0d cycles, required 1", t);
    end
  endtask

  task automatic send_b(input logic [7:0] d);
    int t;
    logic hs;
    b_din = d; b_din_valid = 1'b1; t = 0; hs = 1'b0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = b_din_ready;
      @(posedge clk); t++;
    end
    #1 b_din_valid = 1'b0;
    if (!hs) begin
      compared++; mismatched++;
      $display("FAIL b_send_timeout: din_ready=0 for %0d cycles, required 1", t);
    end
  endtask

  task automatic wait_done_a(output int nd);
    int t;
    nd = 0; t = 0;
    while (t < 200) begin
      @(negedge clk); #1;
      if (a_done) nd++;
      if (!a_busy) break;
      t++;
    end
    if (t >= 200) begin
      compared++; mismatched++;
      $display("FAIL a_done_timeout: busy=%0b, required 0", a_busy);
    end
  endtask

  task automatic wait_done_b(output int nd);
    int t;
    nd = 0; t = 0;
    while (t < 200) begin
      @(negedge clk); #1;
      if (b_done) nd++;
      if (!b_busy) break;
      t++;
    end
    if (t >= 200) begin
      compared++; mismatched++;
      $display("FAIL b_done_timeout: busy=%0b, required 0", b_busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int nd, t, tot;
    logic [9:0] snap;
    a_rst = 1'b1; a_start = 1'b0; a_verify = 1'b0; a_din = '0; a_din_valid = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_verify = 1'b0; b_din = '0; b_din_valid = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("a_reset_outs", 32'({a_din_ready, a_head, a_en, a_busy, a_done, a_error}), 32'h0);
    check("a_reset_cnt", 32'(a_cnt), 32'h0);
    check("b_reset_outs", 32'({b_din_ready, b_head, b_en, b_busy, b_done, b_error}), 32'h0);

    // din_valid in IDLE is not consumed
    tot = en_tot_a;
    a_din = 8'hFF; a_din_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("a_idle_ready", 32'(a_din_ready), 32'h0);
    check("a_idle_shifts", 32'(en_tot_a - tot), 32'h0);
    a_din_valid = 1'b0;

    // Load 0xA5 with a start pulse mid-pass that must be ignored
    push_a(16'b10100101, 8);
    go_a(1'b0);
    send_a(8'hA5);
    go_a(1'b1);
    wait_done_a(nd);
    check("a5_done_pulses", 32'(nd), 32'd1);
    check("a5_bit_cnt", 32'(a_cnt), 32'd8);
    check("a5_chain", 32'(chain_a), 32'hA5);
    check("a5_span", 32'(last_a - first_a + 1), 32'd8);
    check("a5_shifts", 32'(en_n_a), 32'd8);
    check("a5_error", 32'(a_error), 32'h0);

    // Load then verify 0x5A on a healthy chain
    push_a(16'b01011010, 8);
    go_a(1'b0);
    send_a(8'h5A);
    wait_done_a(nd);
    check("5a_load_chain", 32'(chain_a), 32'h5A);
    push_a(16'b01011010, 8);
    go_a(1'b1);
    send_a(8'h5A);
    wait_done_a(nd);
    check("5a_verify_done", 32'(nd), 32'd1);
    check("5a_verify_err", 32'(a_error), 32'h0);
    check("5a_verify_chain", 32'(chain_a), 32'h5A);

    // Stuck-at-0 on chain bit 3 must be flagged and stay flagged
    stuck_a = 8'h08;
    push_a(16'b01011010, 8);
    go_a(1'b1);
    send_a(8'h5A);
    wait_done_a(nd);
    check("fault_err", 32'(a_error), 32'h1);
    repeat (3) @(negedge clk);
    check("fault_err_sticky", 32'(a_error), 32'h1);
    stuck_a = 8'h00;
    push_a(16'b01011010, 8);
    go_a(1'b0);
    check("start_clears_err", 32'(a_error), 32'h0);
    send_a(8'h5A);
    wait_done_a(nd);
    check("reload_err", 32'(a_error), 32'h0);
    check("reload_chain", 32'(chain_a), 32'h5A);

    // Asynchronous reset after four bits of 0xC3
    push_a(16'b1100, 4);
    go_a(1'b0);
    send_a(8'hC3);
    t = 0;
    while (en_n_a < 4 && t < 30) begin
      @(negedge clk); #1; t++;
    end
    check("rst_reached_bit4", 32'(en_n_a), 32'd4);
    a_rst = 1'b1;
    #1;
    check("rst_async_outs", 32'({a_din_ready, a_head, a_en, a_busy, a_done, a_error}), 32'h0);
    check("rst_async_cnt", 32'(a_cnt), 32'h0);
    check("rst_queue_drained", 32'(q_a.size()), 32'h0);
    #1 a_rst = 1'b0;
    push_a(16'b11111111, 8);
    go_a(1'b0);
    send_a(8'hFF);
    wait_done_a(nd);
    check("ff_done", 32'(nd), 32'd1);
    check("ff_bit_cnt", 32'(a_cnt), 32'd8);
    check("ff_chain", 32'(chain_a), 32'hFF);

    // 10-bit chain, back-to-back bytes, partial final byte
    push_b(16'b0011110011, 10);
    go_b(1'b0);
    send_b(8'h3C);
    send_b(8'hC0);
    wait_done_b(nd);
    check("b2b_done", 32'(nd), 32'd1);
    check("b2b_shifts", 32'(en_n_b), 32'd10);
    check("b2b_span", 32'(last_b - first_b + 1), 32'd10);
    check("b2b_ready_bit", 32'(rdy_b), 32'd8);
    check("b2b_bit_cnt", 32'(b_cnt), 32'd10);
    check("b2b_chain", 32'(chain_b), 32'h0F3);

    // Same stream with a 3-cycle host stall after the first byte
    push_b(16'b0011110011, 10);
    go_b(1'b0);
    send_b(8'h3C);
    repeat (9) @(posedge clk);
    #1 snap = chain_b;
    @(posedge clk);
    #1 check("stall_chain_hold", 32'(chain_b), 32'(snap));
    send_b(8'hC0);
    wait_done_b(nd);
    check("stall_done", 32'(nd), 32'd1);
    check("stall_shifts", 32'(en_n_b), 32'd10);
    check("stall_gap", 32'(last_b - first_b + 1 - en_n_b), 32'd3);
    check("stall_bit_cnt", 32'(b_cnt), 32'd10);
    check("stall_chain", 32'(chain_b), 32'h0F3);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
